// File: rtl/matmul_job_sequencer_if.sv
// matmul_job_sequencer_if: job, operand, APB, busy and result signals of the matmul sequencer
interface matmul_job_sequencer_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int MAX_DIM    = 4,
  parameter int ADDR_WIDTH = 16
);
  logic                  job_valid, job_ready;
  logic [15:0]           job_ctrl;
  logic                  op_valid, op_ready;
  logic [BUS_WIDTH-1:0]  op_data;
  logic [MAX_DIM-1:0]    op_strb;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel, penable, pwrite;
  logic [BUS_WIDTH-1:0]  pwdata;
  logic [MAX_DIM-1:0]    pstrb;
  logic                  pready, pslverr;
  logic [BUS_WIDTH-1:0]  prdata;
  logic                  busy;
  logic                  res_valid, res_last;
  logic [BUS_WIDTH-1:0]  res_data;
  logic [1:0]            res_row, res_col;
  logic                  done, error;
  modport master (
    input  job_valid, job_ctrl, op_valid, op_data, op_strb, pready, pslverr, prdata, busy,
    output job_ready, op_ready, paddr, psel, penable, pwrite, pwdata, pstrb,
           res_valid, res_data, res_row, res_col, res_last, done, error
  );
  modport slave (
    output job_valid, job_ctrl, op_valid, op_data, op_strb, pready, pslverr, prdata, busy,
    input  job_ready, op_ready, paddr, psel, penable, pwrite, pwdata, pstrb,
           res_valid, res_data, res_row, res_col, res_last, done, error
  );
endinterface

// File: rtl/matmul_job_sequencer.sv
// matmul_job_sequencer: loads operands over APB, starts the matmul, waits on busy and streams results
module matmul_job_sequencer #(
  parameter int BUS_WIDTH    = 32,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_DIM      = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int BUSY_TIMEOUT = 4096
) (
  input logic clk,
  input logic rst_n,
  matmul_job_sequencer_if.master bus
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int ROW_W = MAX_DIM * DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WR_CTRL, WAIT_HI, WAIT_LO, RD_RES, FINISH} state_t;
  state_t state, state_nx;
  logic [15:0] ctrl;
  logic [1:0] n1, m1, cnt_r, cnt_c;
  logic [TW-1:0] wcnt;
  logic [4:0] region;
  logic rdy_en, accept, launch, xfer_done, step, last, tmo, waiting, err_set, unused_ok;
  assign n1 = ctrl[9:8];
  assign m1 = ctrl[13:12];
  assign unused_ok = ^{ctrl[7:6], ctrl[0]};
  assign bus.job_ready = (state == IDLE) && rdy_en;
  assign bus.op_ready = !bus.psel && (state == LOAD_A || state == LOAD_B);
  assign bus.done = (state == FINISH);
  assign accept = bus.job_valid && bus.job_ready;
  assign xfer_done = bus.psel && bus.penable && bus.pready;
  assign step = xfer_done && !bus.pslverr && state != WR_CTRL;
  assign launch = !bus.psel && (state == WR_CTRL || state == RD_RES || (bus.op_ready && bus.op_valid));
  assign last = (state == RD_RES) ? (cnt_r == n1 && cnt_c == m1) : (state == LOAD_B) ? (cnt_r == m1) : (cnt_r == n1);
  assign waiting = (state == WAIT_HI || state == WAIT_LO);
  assign tmo = (wcnt == TW'(BUSY_TIMEOUT - 1));
  assign err_set = (xfer_done && bus.pslverr) || (waiting && state_nx == FINISH);
  assign region = (state == LOAD_A) ? 5'b00100 : (state == LOAD_B) ? 5'b01000 : (state == RD_RES) ? 5'b10000 : 5'b00000;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: any slave error or busy timeout abandons the job through FINISH
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = bus.job_ctrl[14] ? (bus.job_ctrl[15] ? WR_CTRL : LOAD_B) : LOAD_A;
      LOAD_A:  if (xfer_done) state_nx = bus.pslverr ? FINISH : !last ? LOAD_A : ctrl[15] ? WR_CTRL : LOAD_B;
      LOAD_B:  if (xfer_done) state_nx = bus.pslverr ? FINISH : last ? WR_CTRL : LOAD_B;
      WR_CTRL: if (xfer_done) state_nx = bus.pslverr ? FINISH : WAIT_HI;
      WAIT_HI: state_nx = bus.busy ? WAIT_LO : tmo ? FINISH : WAIT_HI;
      WAIT_LO: state_nx = !bus.busy ? RD_RES : tmo ? FINISH : WAIT_LO;
      RD_RES:  if (xfer_done && (bus.pslverr || last)) state_nx = FINISH;
      default: state_nx = IDLE;
    endcase
  end
  // APB engine, counters, result register and sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_en <= 1'b0;
      ctrl <= '0;
      cnt_r <= '0;
      cnt_c <= '0;
      wcnt <= '0;
      bus.psel <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite <= 1'b0;
      bus.paddr <= '0;
      bus.pwdata <= '0;
      bus.pstrb <= '0;
      bus.res_valid <= 1'b0;
      bus.res_last <= 1'b0;
      bus.res_data <= '0;
      bus.res_row <= '0;
      bus.res_col <= '0;
      bus.error <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) ctrl <= bus.job_ctrl;
      bus.error <= !accept && (bus.error || err_set);
      wcnt <= (waiting && state_nx == state) ? wcnt + TW'(1) : '0;
      bus.psel <= launch || (bus.psel && !xfer_done);
      bus.penable <= bus.psel && !xfer_done;
      if (launch) begin
        bus.paddr <= ADDR_WIDTH'({cnt_c, cnt_r, region});
        bus.pwrite <= (state != RD_RES);
        bus.pwdata <= (state == WR_CTRL) ? BUS_WIDTH'({2'b00, ctrl[13:8], 2'b01, ctrl[5:1], 1'b1}) : (state == RD_RES) ? '0 : BUS_WIDTH'(bus.op_data[ROW_W-1:0]);
        bus.pstrb <= (state == WR_CTRL) ? MAX_DIM'(1) : (state == RD_RES) ? '0 : bus.op_strb;
      end
      cnt_c <= (state == IDLE) ? '0 : (step && state == RD_RES) ? (cnt_c == m1 ? '0 : cnt_c + 2'd1) : cnt_c;
      cnt_r <= (state == IDLE) ? '0 : !step ? cnt_r : last ? '0 : (state != RD_RES || cnt_c == m1) ? cnt_r + 2'd1 : cnt_r;
      bus.res_valid <= step && state == RD_RES;
      bus.res_last <= step && state == RD_RES && last;
      if (step && state == RD_RES) begin
        bus.res_data <= bus.prdata;
        bus.res_row <= cnt_r;
        bus.res_col <= cnt_c;
      end
    end
endmodule
